byte_serial_adder: RTL
======================

// Module: byte_serial_adder
// PURPOSE
// - Upstream sequencer for s8_bit_adder. Adds two NBYTES-wide operands one byte per clock.
// - Each cycle it drives one byte pair plus a registered carry into a single instantiated s8_bit_adder.
// - Captures the byte sum and chains carry_out back into the next byte.
// - Gives wide additions in the CPU datapath with one 8-bit adder instead of NBYTES of them.
// PARAMETERS
// - NBYTES  4  operand width in bytes; legal range 1..16; operand width W = 8*NBYTES
// PORTS
// - clk       in   1   single clock; all state updates on rising edge
// - rst       in   1   synchronous, active-high reset
// - start     in   1   request; sampled only in IDLE
// - op_a      in   W   operand A; sampled with start
// - op_b      in   W   operand B; sampled with start
// - carry_in  in   1   carry into byte 0; sampled with start
// - busy      out  1   high in RUN and DONE
// - done      out  1   one-cycle pulse; result valid
// - sum       out  W   result; held until the next accepted start
// - carry_out out  1   carry out of the MSB byte; held with sum
// - ovf       out  1   only when OVERFLOW_FLAG_EN is defined (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=1 at a clock edge) puts every register in its reset state:
//   - state = IDLE; busy = 0; done = 0; sum = 0; carry_out = 0; ovf = 0.
//   - Byte index = 0; carry register = 0; operand latches = 0.
//   - Reset wins over every other input in the same cycle.
// - FSM states: IDLE -> RUN -> DONE -> IDLE.
// - IDLE:
//   - When start=1, latch op_a, op_b and carry_in (carry_in goes into the carry register).
//   - Set index = 0 and go to RUN.
//   - Clear sum and carry_out at acceptance.
// - RUN, each cycle:
//   - Adder inputs: a = A[8*idx+:8], b = B[8*idx+:8], carry_in = carry register.
//   - Registered updates: sum[8*idx+:8] <= adder sum; carry register <= adder carry_out; idx <= idx+1.
//   - On idx == NBYTES-1, go to DONE and load carry_out from the adder carry.
// - DONE: done=1 for exactly this cycle, then IDLE unconditionally.
// - Latency: start sampled at edge T; RUN occupies cycles T+1..T+NBYTES; done is high in cycle T+NBYTES+1.
// - Throughput: a new start is accepted no earlier than the cycle after DONE.
// - start while busy (RUN or DONE) is ignored and not queued. Operand changes while busy have no effect.
// - Arithmetic is unsigned modulo 2^W. carry_out = bit W of op_a + op_b + carry_in.
// - NBYTES=1: one RUN cycle; done at T+2.
// - Byte index width = clog2(NBYTES), minimum 1 bit. The index never wraps past NBYTES-1.
// - Reset mid-RUN or mid-DONE: next cycle is IDLE with all outputs at reset values. No done pulse is issued for the aborted operation.
// CONFIGURATION
// - OVERFLOW_FLAG_EN defined:
//   - Adds output port ovf (1 bit), the two's-complement overflow flag.
//   - ovf = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]), registered on the RUN->DONE transition.
//   - Held with sum; cleared at reset and at start acceptance.
// - OVERFLOW_FLAG_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.
// TESTING (NBYTES=4 unless noted)
// - op_a=0x000000FF, op_b=0x00000001, carry_in=0, start at T -> done at T+5 only, sum=0x00000100, carry_out=0, busy high T+1..T+5.
// - op_a=0xFFFFFFFF, op_b=0x00000000, carry_in=1 -> sum=0x00000000, carry_out=1 (carry ripples through all 4 bytes).
// - NBYTES=1: op_a=37, op_b=72, carry_in=1 -> sum=110, carry_out=0, done at T+2; op_a=240, op_b=127, carry_in=0 -> sum=111, carry_out=1.
// - start held high continuously from T -> first done at T+5, next accepted start at T+6, next done at T+11; no done in between.
// - rst=1 at T+2 mid-RUN -> IDLE at T+3, sum=0, carry_out=0, busy=0, no done until a new start.
// - OVERFLOW_FLAG_EN: op_a=0x7FFFFFFF, op_b=0x00000001, carry_in=0 -> sum=0x80000000, ovf=1, carry_out=0; op_a=0xFFFFFFFF, op_b=0x00000001, carry_in=0 -> ovf=0, carry_out=1.

Source files
------------

// File: rtl/byte_serial_adder.sv
// byte_serial_adder: adds two NBYTES-wide operands one byte per clock through
// a single 8-bit adder (s8_bit_adder), rippling the carry through a register.
// Optional feature macro: OVERFLOW_FLAG_EN adds the two's-complement ovf output.

// 8-bit adder with carry in/out; the combinational datapath shared by every byte.
module s8_bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       carry_out
);
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {8'b0, carry_in};
endmodule

module byte_serial_adder #(
    parameter int NBYTES = 4,
    parameter int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         carry_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic         ovf
`endif
);
    // Index must be at least one bit wide even for a single-byte adder.
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NBYTES-1:0][7:0]  a_q, a_d;
    logic [NBYTES-1:0][7:0]  b_q, b_d;
    logic [NBYTES-1:0][7:0]  sum_q, sum_d;
    logic                    cy_q, cy_d;
    logic                    cout_q, cout_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;

    logic [7:0] a_byte, b_byte, s_byte;
    logic       s_cout;

    // Select the operand bytes addressed by the current index.
    always_comb begin
        a_byte = 8'h00;
        b_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IW'(i)) begin
                a_byte = a_q[i];
                b_byte = b_q[i];
            end
        end
    end

    s8_bit_adder u_add (
        .a         (a_byte),
        .b         (b_byte),
        .carry_in  (cy_q),
        .sum       (s_byte),
        .carry_out (s_cout)
    );

    // Next-state and registered-output logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    cy_d    = carry_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_q == IW'(i)) sum_d[i] = s_byte;
                end
                cy_d = s_cout;
                if (idx_q == LAST_IDX) begin
                    // a_byte/b_byte/s_byte hold the MSB byte here.
                    cout_d  = s_cout;
                    ovf_d   = (a_byte[7] == b_byte[7]) && (s_byte[7] != a_byte[7]);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single state register; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cy_q    <= cy_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf       = ovf_q;
`else
    // Overflow flop is optimised away when the flag is not exported.
    logic ovf_unused;
    assign ovf_unused = ovf_q;
`endif

endmodule
